// File: rtl/mem_bus_demux.sv
// mem_bus_demux: routes one CPU data-memory request to data memory (target 0)
// or the MMIO region (target 1), and returns the selected target's response.
// Only one transaction is outstanding at a time.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   req_*_i / req_ready_o CPU request channel (valid/ready handshake)
//   resp_*_o              one-cycle response pulse; rdata holds until the next response
//   t0_* / t1_*           target request buses (latched fields) and response inputs
//
// Optional feature: define MEM_DEMUX_TIMEOUT_EN to enable a WAIT-state watchdog.
// If no response arrives within TIMEOUT cycles, the block returns resp_err = 1
// with rdata 32'hDEAD_BEEF. Without the macro, resp_err is tied to 0 and WAIT
// persists indefinitely.
module mem_bus_demux #(
  parameter int unsigned   N       = 32,
  parameter int unsigned   AW      = 32,
  parameter logic [AW-1:0] T1_BASE = 32'hFFFF_0000,
  parameter logic [AW-1:0] T1_MASK = 32'hFFFF_0000
`ifdef MEM_DEMUX_TIMEOUT_EN
  ,
  parameter int unsigned   TIMEOUT = 255
`endif
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic [AW-1:0]  req_addr_i,
  input  logic           req_we_i,
  input  logic [N-1:0]   req_wdata_i,
  input  logic [N/8-1:0] req_wstrb_i,
  output logic           resp_valid_o,
  output logic [N-1:0]   resp_rdata_o,
  output logic           resp_err_o,
  output logic           t0_valid_o,
  output logic           t1_valid_o,
  input  logic           t0_ready_i,
  input  logic           t1_ready_i,
  output logic [AW-1:0]  t0_addr_o,
  output logic [AW-1:0]  t1_addr_o,
  output logic           t0_we_o,
  output logic           t1_we_o,
  output logic [N-1:0]   t0_wdata_o,
  output logic [N-1:0]   t1_wdata_o,
  output logic [N/8-1:0] t0_wstrb_o,
  output logic [N/8-1:0] t1_wstrb_o,
  input  logic           t0_resp_valid_i,
  input  logic           t1_resp_valid_i,
  input  logic [N-1:0]   t0_rdata_i,
  input  logic [N-1:0]   t1_rdata_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e         state_q, state_d;
  logic           sel_q;
  logic [AW-1:0]  addr_q;
  logic           we_q;
  logic [N-1:0]   wdata_q;
  logic [N/8-1:0] wstrb_q;
  logic           resp_valid_q, resp_valid_d;
  logic [N-1:0]   resp_rdata_q, resp_rdata_d;
  logic           accept;

  // Only the selected target's handshake signals are observed.
  logic           tgt_ready;
  logic           tgt_resp;
  logic [N-1:0]   tgt_rdata;

  assign tgt_ready = sel_q ? t1_ready_i      : t0_ready_i;
  assign tgt_resp  = sel_q ? t1_resp_valid_i : t0_resp_valid_i;
  assign tgt_rdata = sel_q ? t1_rdata_i      : t0_rdata_i;

  assign req_ready_o = (state_q == StIdle) & ~rst_i;
  assign accept      = req_valid_i & req_ready_o;

`ifdef MEM_DEMUX_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            resp_err_q, resp_err_d;
  logic            cnt_hit;
  // Count reaches TIMEOUT on this WAIT cycle.
  assign cnt_hit = ({1'b0, cnt_q} + 1'b1) == (CntW + 1)'(TIMEOUT);
`endif

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
`ifdef MEM_DEMUX_TIMEOUT_EN
    cnt_d        = cnt_q;
    resp_err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StIssue;
      end
      StIssue: begin
        if (tgt_ready) begin
          state_d = StWait;
`ifdef MEM_DEMUX_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StWait: begin
        // A response in the same cycle as the timeout takes priority.
        if (tgt_resp) begin
          state_d      = StIdle;
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? '0 : tgt_rdata;
        end
`ifdef MEM_DEMUX_TIMEOUT_EN
        else if (cnt_hit) begin
          state_d      = StIdle;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = N'(32'hDEAD_BEEF);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      sel_q        <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      if (accept) begin
        sel_q   <= ((req_addr_i & T1_MASK) == T1_BASE);
        addr_q  <= req_addr_i;
        we_q    <= req_we_i;
        wdata_q <= req_wdata_i;
        wstrb_q <= req_wstrb_i;
      end
    end
  end

`ifdef MEM_DEMUX_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      resp_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      resp_err_q <= resp_err_d;
    end
  end
  assign resp_err_o = resp_err_q;
`else
  assign resp_err_o = 1'b0;
`endif

  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;

  assign t0_valid_o = (state_q == StIssue) & ~sel_q;
  assign t1_valid_o = (state_q == StIssue) &  sel_q;

  // Both buses carry the latched fields; only the valid line differs.
  assign t0_addr_o  = addr_q;
  assign t1_addr_o  = addr_q;
  assign t0_we_o    = we_q;
  assign t1_we_o    = we_q;
  assign t0_wdata_o = wdata_q;
  assign t1_wdata_o = wdata_q;
  assign t0_wstrb_o = wstrb_q;
  assign t1_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_mem_bus_demux.sv
module tb_mem_bus_demux;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        t0_valid, t1_valid, t0_ready, t1_ready;
  logic [31:0] t0_addr, t1_addr, t0_wdata, t1_wdata, t0_rdata, t1_rdata;
  logic        t0_we, t1_we, t0_resp_valid, t1_resp_valid;
  logic [3:0]  t0_wstrb, t1_wstrb;

  int n_vec = 0;
  int n_err = 0;

  mem_bus_demux #(
`ifdef MEM_DEMUX_TIMEOUT_EN
    .TIMEOUT(4),
`endif
    .N(32),
    .AW(32)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .t0_valid_o(t0_valid), .t1_valid_o(t1_valid),
    .t0_ready_i(t0_ready), .t1_ready_i(t1_ready),
    .t0_addr_o(t0_addr), .t1_addr_o(t1_addr),
    .t0_we_o(t0_we), .t1_we_o(t1_we),
    .t0_wdata_o(t0_wdata), .t1_wdata_o(t1_wdata),
    .t0_wstrb_o(t0_wstrb), .t1_wstrb_o(t1_wstrb),
    .t0_resp_valid_i(t0_resp_valid), .t1_resp_valid_i(t1_resp_valid),
    .t0_rdata_i(t0_rdata), .t1_rdata_i(t1_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          rdly;       // ISSUE cycles before the target raises ready
    logic        spur;       // spurious response from the other target first
    logic [31:0] trdata;     // data returned by the selected target
    logic        sel;        // expected target
    logic [31:0] exp_rdata;  // expected resp_rdata
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    req_valid = 1'b1; req_addr = v.addr; req_we = v.we;
    req_wdata = v.wdata; req_wstrb = v.wstrb;
    chk("req_ready idle", req_ready, 1);
    step();
    // Scramble the request inputs: the targets must see the latched copy.
    req_valid = 1'b0; req_addr = 32'h5555_5555; req_we = ~v.we;
    req_wdata = 32'h0; req_wstrb = 4'h0;
    for (int d = 0; d <= v.rdly; d++) begin
      chk("t0_valid issue", t0_valid, !v.sel);
      chk("t1_valid issue", t1_valid, v.sel);
      chk("addr held", v.sel ? t1_addr : t0_addr, v.addr);
      chk("other addr", v.sel ? t0_addr : t1_addr, v.addr);
      chk("we held", v.sel ? t1_we : t0_we, v.we);
      chk("wdata held", v.sel ? t1_wdata : t0_wdata, v.wdata);
      chk("wstrb held", v.sel ? t1_wstrb : t0_wstrb, v.wstrb);
      chk("req_ready busy", req_ready, 0);
      // The non-selected target's ready is held high and must be ignored.
      t0_ready = v.sel ? 1'b1 : (d == v.rdly);
      t1_ready = v.sel ? (d == v.rdly) : 1'b1;
      step();
    end
    t0_ready = 1'b0; t1_ready = 1'b0;
    chk("t0_valid wait", t0_valid, 0);
    chk("t1_valid wait", t1_valid, 0);
    if (v.spur) begin
      if (v.sel) begin t0_resp_valid = 1'b1; t0_rdata = 32'hBAD0_BAD0; end
      else       begin t1_resp_valid = 1'b1; t1_rdata = 32'hBAD0_BAD0; end
      step();
      t0_resp_valid = 1'b0; t1_resp_valid = 1'b0;
      chk("spurious resp ignored", resp_valid, 0);
    end
    if (v.sel) begin t1_resp_valid = 1'b1; t1_rdata = v.trdata; end
    else       begin t0_resp_valid = 1'b1; t0_rdata = v.trdata; end
    step();
    t0_resp_valid = 1'b0; t1_resp_valid = 1'b0;
    t0_rdata = 32'h0; t1_rdata = 32'h0;
    chk("resp_valid", resp_valid, 1);
    chk("resp_rdata", resp_rdata, v.exp_rdata);
    chk("resp_err", resp_err, 0);
    chk("req_ready after resp", req_ready, 1);
    step();
    chk("resp_valid one cycle", resp_valid, 0);
    chk("resp_rdata holds", resp_rdata, v.exp_rdata);
  endtask

  vec_t vecs[5];
  int   seen;

  initial begin
    vecs[0] = '{32'h0000_0010, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h1234_5678, 1'b0, 32'h1234_5678};
    vecs[1] = '{32'hFFFF_0004, 1'b1, 32'hA5A5_A5A5, 4'b0011, 3, 1'b0, 32'h0000_55AA, 1'b1,
                32'h0};
    vecs[2] = '{32'hFFFE_FFFC, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D};
    vecs[3] = '{32'hFFFF_0000, 1'b0, 32'h0, 4'hF, 1, 1'b0, 32'hCAFE_BABE, 1'b1, 32'hCAFE_BABE};
    vecs[4] = '{32'hFFFF_0008, 1'b0, 32'h0, 4'hF, 0, 1'b1, 32'h1357_9BDF, 1'b1, 32'h1357_9BDF};

    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_we = 1'b0;
    req_wdata = 32'h0; req_wstrb = 4'h0;
    t0_ready = 1'b0; t1_ready = 1'b0; t0_resp_valid = 1'b0; t1_resp_valid = 1'b0;
    t0_rdata = 32'h0; t1_rdata = 32'h0;
    #1;
    chk("reset req_ready", req_ready, 0);
    chk("reset t0_valid", t0_valid, 0);
    chk("reset t1_valid", t1_valid, 0);
    chk("reset resp_valid", resp_valid, 0);
    chk("reset resp_rdata", resp_rdata, 0);
    chk("reset t0_addr", t0_addr, 0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("req_ready after reset", req_ready, 1);

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Reset while in ISSUE: everything clears asynchronously, no response follows.
    req_valid = 1'b1; req_addr = 32'hFFFF_0010; req_we = 1'b1;
    req_wdata = 32'h1111_2222; req_wstrb = 4'hF;
    step();
    req_valid = 1'b0;
    chk("pre-reset t1_valid", t1_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid reset t1_valid", t1_valid, 0);
    chk("mid reset t1_addr", t1_addr, 0);
    chk("mid reset t1_wdata", t1_wdata, 0);
    chk("mid reset t1_we", t1_we, 0);
    chk("mid reset resp_rdata", resp_rdata, 0);
    chk("mid reset req_ready", req_ready, 0);
    step();
    rst = 1'b0;
    #1;
    chk("post reset req_ready", req_ready, 1);
    seen = 0;
    t1_ready = 1'b1; t1_resp_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      if (resp_valid) seen++;
    end
    t1_ready = 1'b0; t1_resp_valid = 1'b0;
    chk("no resp after abort", seen, 0);
    chk("idle after abort", req_ready, 1);

    // Target never responds.
    req_valid = 1'b1; req_addr = 32'h0000_0020; req_we = 1'b0;
    step();
    req_valid = 1'b0; t0_ready = 1'b1;
    step();
    t0_ready = 1'b0;
    seen = 0;
    for (int c = 0; c < 1000 && seen == 0; c++) begin
      step();
      if (resp_valid) begin
        seen = 1;
`ifdef MEM_DEMUX_TIMEOUT_EN
        chk("timeout err", resp_err, 1);
        chk("timeout rdata", resp_rdata, 32'hDEAD_BEEF);
`endif
      end
    end
`ifdef MEM_DEMUX_TIMEOUT_EN
    chk("timeout resp seen", seen, 1);
`else
    chk("no resp without timeout", seen, 0);
    chk("still busy in WAIT", req_ready, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
